reg_status_file: RTL and testbench
==================================

# reg_status_file

Parametrised architectural register file with per-register rename status for the Tomasulo core. It generalises the two-port scalar register file to NREAD read ports and adds several behaviours: an explicit issue valid, same-cycle commit bypass, a global flush for mispredict recovery, and a live busy-register counter. It sits between Decoder (read and issue side) and RoB (commit side and value query).

## Interface
- XLEN, 32: register data width
- NREGS, 32: architectural registers; x0 hardwired zero
- ROB_W, 4: RoB index width
- NREAD, 2: read ports serving Decoder
- AW: derived, $clog2(NREGS)
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  mispredict recovery; clears all rename status
- issue_valid  in  1  Decoder issues an instruction this cycle
- issue_rd  in  AW  destination register of the issued instruction
- issue_rob_id  in  ROB_W  RoB slot of the issued instruction
- commit_valid  in  1  RoB retires an instruction this cycle
- commit_rd  in  AW  destination of the retiring instruction
- commit_rob_id  in  ROB_W  RoB slot of the retiring instruction
- commit_value  in  XLEN  result of the retiring instruction
- rd_addr  in  NREAD*AW  packed read addresses
- ask_rob_id  out  NREAD*ROB_W  per-port RoB query tag
- get_value  in  NREAD*XLEN  RoB value for each query
- get_ready  in  NREAD  RoB value valid for each query
- rd_value  out  NREAD*XLEN  operand value; 0 when rd_dep is set
- rd_dep  out  NREAD  operand still pending
- rd_tag  out  NREAD*ROB_W  producer RoB id when rd_dep is set, else 0
- busy_cnt  out  AW+1  number of registers currently renamed

## Operation
- State per register r: value[r], busy[r], tag[r]. Register x0 is never written and never busy.
- Read resolution is combinational and independent per port p, for address a. The first matching rule applies:
  1. a==0: value 0, dep 0.
  2. issue_valid && !flush && issue_rd==a && a!=0: dep 1, tag issue_rob_id. This covers a same-cycle rename.
  3. busy[a]: query ask_rob_id=tag[a].
     - If commit_valid && commit_rob_id==tag[a]: value commit_value, dep 0.
     - Else if get_ready[p]: value get_value, dep 0.
     - Else: dep 1, tag tag[a].
  4. Otherwise: value is commit_value if commit_valid && commit_rd==a, else value[a]; dep 0.
- ask_rob_id is 0 for any port not in rule 3.
- Sequential update, on clk when rdy=1:
  - Commit with commit_rd!=0 writes value[commit_rd].
  - Commit clears busy/tag of commit_rd if busy and tag==commit_rob_id.
  - Issue with issue_rd!=0 and !flush sets busy=1, tag=issue_rob_id. Issue overrides a same-register commit clear.
  - flush clears every busy and tag. The commit value write still occurs. A same-cycle issue is dropped.
- busy_cnt tracks the popcount of busy[] incrementally:
  - +1 when issue targets a non-busy register.
  - -1 when commit clears a register.
  - Net 0 when both apply to the same register. Issue to an already-busy register that a commit is clearing also gives a net 0.
  - Reset to 0 on flush.

## Timing
- Read ports: zero latency, purely combinational from rd_addr, issue and commit inputs, and the RoB response.
- State changes are visible on reads one cycle after the issue or commit edge.
- Reset: all value, busy and tag entries 0, and busy_cnt 0. Outputs are then rd_value 0, rd_dep 0, rd_tag 0, ask_rob_id 0.
- rst has priority over flush. flush has priority over issue.
- rdy=0: no state change, even if flush or commit is asserted. Reads still resolve combinationally.
- No handshakes: issue and commit are single-cycle pulses and are always accepted.

## Structure
- Shared package rs_pkg:
  - XLEN, ROB_W and AW defaults.
  - A typedef for the read-port result struct {value, dep, tag}.
- Sub-module reg_read_port: implements rules 1–4 for one port. It is instantiated NREAD times via generate.
- Top level: state arrays, update logic, busy_cnt.

## Test plan
- Reset, then read x5 on both ports: rd_value 0, rd_dep 0, busy_cnt 0.
- Issue rd=5, rob=3; same cycle read x5: dep 1, tag 3.
  - Next cycle, get_ready=0: dep 1, ask_rob_id 3.
  - Then get_ready=1, get_value=0x55: value 0x55, dep 0.
- Commit rd=5, rob=3, value 0xDEAD: during that cycle a read gives 0xDEAD, dep 0; next cycle busy_cnt drops 1→0 and value[5]=0xDEAD.
- Issue rd=7 rob=1, then issue rd=7 rob=2, then commit rob=1 value 9: x7 stays busy with tag 2 and reads dep 1; value[7]=9; busy_cnt stays 1.
- Issue rd=4, rd=6, rd=8, then flush with a simultaneous issue of rd=9: next cycle busy_cnt 0 and all reads dep 0.
- Issue rd=0: no state change and busy_cnt unchanged. Also hold rdy=0 with a commit rd=3 value 7: value[3] is unchanged after the edge.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared definitions for the register status file.
// Holds the default widths used by reg_status_file and the read-port
// result record {value, dep, tag}.
package rs_pkg;

    localparam int unsigned DEF_XLEN  = 32;
    localparam int unsigned DEF_NREGS = 32;
    localparam int unsigned DEF_ROB_W = 4;
    localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

    // Resolved operand as seen by the Decoder on one read port.
    typedef struct packed {
        logic [DEF_XLEN-1:0]  value;
        logic                 dep;
        logic [DEF_ROB_W-1:0] tag;
    } rd_result_t;

endpackage

// File: rtl/reg_read_port.sv
// One operand read port of reg_status_file.
// Resolves an architectural register address against the stored state,
// a same-cycle issue (rename), a same-cycle commit and the RoB response.
// Ports:
//   addr                           register address being read
//   issue_valid/flush/issue_rd/issue_rob_id   issue side of this cycle
//   commit_valid/commit_rd/commit_rob_id/commit_value   commit side
//   reg_value/reg_busy/reg_tag     stored state of register addr
//   get_value/get_ready            RoB answer to ask_rob_id
//   value/dep/tag                  resolved operand
//   ask_rob_id                     RoB query tag, 0 when not querying
module reg_read_port
    import rs_pkg::*;
#(
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned ROB_W = DEF_ROB_W,
    parameter int unsigned AW    = DEF_AW
) (
    input  logic [AW-1:0]    addr,
    input  logic             issue_valid,
    input  logic             flush,
    input  logic [AW-1:0]    issue_rd,
    input  logic [ROB_W-1:0] issue_rob_id,
    input  logic             commit_valid,
    input  logic [AW-1:0]    commit_rd,
    input  logic [ROB_W-1:0] commit_rob_id,
    input  logic [XLEN-1:0]  commit_value,
    input  logic [XLEN-1:0]  reg_value,
    input  logic             reg_busy,
    input  logic [ROB_W-1:0] reg_tag,
    input  logic [XLEN-1:0]  get_value,
    input  logic             get_ready,
    output logic [XLEN-1:0]  value,
    output logic             dep,
    output logic [ROB_W-1:0] tag,
    output logic [ROB_W-1:0] ask_rob_id
);

    always_comb begin
        value      = '0;
        dep        = 1'b0;
        tag        = '0;
        ask_rob_id = '0;
        if (addr == '0) begin
            // x0 reads as zero, never pending
        end else if (issue_valid && !flush && issue_rd == addr) begin
            // renamed this very cycle: the new producer wins
            dep = 1'b1;
            tag = issue_rob_id;
        end else if (reg_busy) begin
            ask_rob_id = reg_tag;
            if (commit_valid && commit_rob_id == reg_tag) begin
                value = commit_value;
            end else if (get_ready) begin
                value = get_value;
            end else begin
                dep = 1'b1;
                tag = reg_tag;
            end
        end else if (commit_valid && commit_rd == addr) begin
            value = commit_value;
        end else begin
            value = reg_value;
        end
    end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status.
// Decoder reads NREAD operands and issues renames; RoB commits results
// and answers value queries for still-renamed operands.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), flush
//   issue_valid/issue_rd/issue_rob_id          rename request
//   commit_valid/commit_rd/commit_rob_id/commit_value   retirement
//   rd_addr                                    packed read addresses
//   ask_rob_id / get_value / get_ready         per-port RoB query
//   rd_value / rd_dep / rd_tag                 per-port operand result
//   busy_cnt                                   number of renamed registers
module reg_status_file
    import rs_pkg::*;
#(
    parameter int unsigned XLEN  = DEF_XLEN,
    parameter int unsigned NREGS = DEF_NREGS,
    parameter int unsigned ROB_W = DEF_ROB_W,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  flush,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    input  logic [ROB_W-1:0]      issue_rob_id,
    input  logic                  commit_valid,
    input  logic [AW-1:0]         commit_rd,
    input  logic [ROB_W-1:0]      commit_rob_id,
    input  logic [XLEN-1:0]       commit_value,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*ROB_W-1:0] ask_rob_id,
    input  logic [NREAD*XLEN-1:0] get_value,
    input  logic [NREAD-1:0]      get_ready,
    output logic [NREAD*XLEN-1:0] rd_value,
    output logic [NREAD-1:0]      rd_dep,
    output logic [NREAD*ROB_W-1:0] rd_tag,
    output logic [AW:0]           busy_cnt
);

    logic [XLEN-1:0]  value_q [NREGS];
    logic [ROB_W-1:0] tag_q   [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [AW:0]      cnt_q;

    logic issue_eff;
    logic commit_clear;
    logic same_reg;
    logic cnt_inc;
    logic cnt_dec;

    assign issue_eff    = issue_valid && !flush && issue_rd != '0;
    assign commit_clear = commit_valid && busy_q[commit_rd] &&
                          tag_q[commit_rd] == commit_rob_id;
    // A re-rename of the register being cleared keeps it busy: net zero.
    assign same_reg     = issue_eff && commit_clear && issue_rd == commit_rd;
    assign cnt_inc      = issue_eff && !busy_q[issue_rd];
    assign cnt_dec      = commit_clear && !same_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else if (rdy) begin
            if (commit_valid && commit_rd != '0)
                value_q[commit_rd] <= commit_value;
            if (flush) begin
                for (int unsigned r = 0; r < NREGS; r++)
                    tag_q[r] <= '0;
                busy_q <= '0;
                cnt_q  <= '0;
            end else begin
                // issue assignments come last so they override the clear
                if (commit_clear) begin
                    busy_q[commit_rd] <= 1'b0;
                    tag_q[commit_rd]  <= '0;
                end
                if (issue_eff) begin
                    busy_q[issue_rd] <= 1'b1;
                    tag_q[issue_rd]  <= issue_rob_id;
                end
                cnt_q <= cnt_q + {{AW{1'b0}}, cnt_inc} - {{AW{1'b0}}, cnt_dec};
            end
        end
    end

    assign busy_cnt = cnt_q;

    for (genvar p = 0; p < NREAD; p++) begin : g_port
        logic [AW-1:0] a;
        assign a = rd_addr[p*AW +: AW];

        reg_read_port #(
            .XLEN (XLEN),
            .ROB_W(ROB_W),
            .AW   (AW)
        ) u_port (
            .addr         (a),
            .issue_valid  (issue_valid),
            .flush        (flush),
            .issue_rd     (issue_rd),
            .issue_rob_id (issue_rob_id),
            .commit_valid (commit_valid),
            .commit_rd    (commit_rd),
            .commit_rob_id(commit_rob_id),
            .commit_value (commit_value),
            .reg_value    (value_q[a]),
            .reg_busy     (busy_q[a]),
            .reg_tag      (tag_q[a]),
            .get_value    (get_value[p*XLEN +: XLEN]),
            .get_ready    (get_ready[p]),
            .value        (rd_value[p*XLEN +: XLEN]),
            .dep          (rd_dep[p]),
            .tag          (rd_tag[p*ROB_W +: ROB_W]),
            .ask_rob_id   (ask_rob_id[p*ROB_W +: ROB_W])
        );
    end

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_reg_status_file;
    import rs_pkg::*;

    localparam int unsigned XLEN  = DEF_XLEN;
    localparam int unsigned NREGS = DEF_NREGS;
    localparam int unsigned ROB_W = DEF_ROB_W;
    localparam int unsigned AW    = DEF_AW;
    localparam int unsigned NREAD = 2;

    logic                   clk = 1'b0;
    logic                   rst, rdy, flush;
    logic                   issue_valid;
    logic [AW-1:0]          issue_rd;
    logic [ROB_W-1:0]       issue_rob_id;
    logic                   commit_valid;
    logic [AW-1:0]          commit_rd;
    logic [ROB_W-1:0]       commit_rob_id;
    logic [XLEN-1:0]        commit_value;
    logic [NREAD*AW-1:0]    rd_addr;
    logic [NREAD*ROB_W-1:0] ask_rob_id;
    logic [NREAD*XLEN-1:0]  get_value;
    logic [NREAD-1:0]       get_ready;
    logic [NREAD*XLEN-1:0]  rd_value;
    logic [NREAD-1:0]       rd_dep;
    logic [NREAD*ROB_W-1:0] rd_tag;
    logic [AW:0]            busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [XLEN-1:0]  m_val  [NREGS];
    logic             m_busy [NREGS];
    logic [ROB_W-1:0] m_tag  [NREGS];

    always #5 clk = ~clk;

    reg_status_file #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .ROB_W(ROB_W),
        .NREAD(NREAD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_rob_id (issue_rob_id),
        .commit_valid (commit_valid),
        .commit_rd    (commit_rd),
        .commit_rob_id(commit_rob_id),
        .commit_value (commit_value),
        .rd_addr      (rd_addr),
        .ask_rob_id   (ask_rob_id),
        .get_value    (get_value),
        .get_ready    (get_ready),
        .rd_value     (rd_value),
        .rd_dep       (rd_dep),
        .rd_tag       (rd_tag),
        .busy_cnt     (busy_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic rd_result_t model_read(input int p);
        rd_result_t       r;
        logic [AW-1:0]    a;
        r = '0;
        a = rd_addr[p*AW +: AW];
        if (a == 0) return r;
        if (issue_valid && !flush && issue_rd == a) begin
            r.dep = 1'b1;
            r.tag = issue_rob_id;
        end else if (m_busy[a]) begin
            if (commit_valid && commit_rob_id == m_tag[a]) r.value = commit_value;
            else if (get_ready[p])                         r.value = get_value[p*XLEN +: XLEN];
            else begin
                r.dep = 1'b1;
                r.tag = m_tag[a];
            end
        end else begin
            r.value = (commit_valid && commit_rd == a) ? commit_value : m_val[a];
        end
        return r;
    endfunction

    function automatic logic [ROB_W-1:0] model_ask(input int p);
        logic [AW-1:0] a;
        a = rd_addr[p*AW +: AW];
        if (a == 0 || (issue_valid && !flush && issue_rd == a) || !m_busy[a]) return '0;
        return m_tag[a];
    endfunction

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < int'(NREGS); r++) if (m_busy[r]) c++;
        return c;
    endfunction

    task automatic model_update();
        if (rst) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
            end
        end else if (rdy) begin
            if (commit_valid && commit_rd != 0) m_val[commit_rd] = commit_value;
            if (flush) begin
                for (int r = 0; r < int'(NREGS); r++) begin
                    m_busy[r] = 1'b0; m_tag[r] = '0;
                end
            end else begin
                if (commit_valid && m_busy[commit_rd] && m_tag[commit_rd] == commit_rob_id) begin
                    m_busy[commit_rd] = 1'b0; m_tag[commit_rd] = '0;
                end
                if (issue_valid && issue_rd != 0) begin
                    m_busy[issue_rd] = 1'b1; m_tag[issue_rd] = issue_rob_id;
                end
            end
        end
    endtask

    task automatic idle();
        rst = 1'b0; rdy = 1'b1; flush = 1'b0;
        issue_valid = 1'b0; issue_rd = '0; issue_rob_id = '0;
        commit_valid = 1'b0; commit_rd = '0; commit_rob_id = '0; commit_value = '0;
        get_value = '0; get_ready = '0;
    endtask

    task automatic set_addr(input int a0, input int a1);
        rd_addr[0 +: AW]  = AW'(a0);
        rd_addr[AW +: AW] = AW'(a1);
    endtask

    // Inputs are driven 1 time unit after the rising edge; reads are
    // sampled 4 units later, well before the next rising edge.
    task automatic settle();
        rd_result_t e;
        #4;
        for (int p = 0; p < int'(NREAD); p++) begin
            e = model_read(p);
            check($sformatf("value%0d", p), 64'(rd_value[p*XLEN +: XLEN]), 64'(e.value));
            check($sformatf("dep%0d", p),   64'(rd_dep[p]),                64'(e.dep));
            check($sformatf("tag%0d", p),   64'(rd_tag[p*ROB_W +: ROB_W]), 64'(e.tag));
            check($sformatf("ask%0d", p),   64'(ask_rob_id[p*ROB_W +: ROB_W]), 64'(model_ask(p)));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check("busy_cnt", 64'(busy_cnt), 64'(model_count()));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        set_addr(5, 5);
        @(posedge clk); model_update();
        @(posedge clk); model_update();
        #1;
        idle();

        // reset state
        settle();
        check("rst_value", 64'(rd_value), 64'(0));
        check("rst_dep",   64'(rd_dep),   64'(0));
        check("rst_cnt",   64'(busy_cnt), 64'(0));
        tick();

        // same-cycle rename
        issue_valid = 1'b1; issue_rd = 5; issue_rob_id = 3;
        settle();
        check("ren_dep", 64'(rd_dep[0]), 64'(1));
        check("ren_tag", 64'(rd_tag[0 +: ROB_W]), 64'(3));
        tick(); idle();
        settle();
        check("wait_dep", 64'(rd_dep[0]), 64'(1));
        check("wait_ask", 64'(ask_rob_id[0 +: ROB_W]), 64'(3));
        get_ready = 2'b11; get_value = {32'h55, 32'h55};
        settle();
        check("rob_value", 64'(rd_value[0 +: XLEN]), 64'h55);
        check("rob_dep",   64'(rd_dep[0]), 64'(0));
        check("cnt_one",   64'(busy_cnt), 64'(1));
        tick(); idle();

        // commit bypass and retirement
        commit_valid = 1'b1; commit_rd = 5; commit_rob_id = 3; commit_value = 32'hDEAD;
        settle();
        check("cbyp_value", 64'(rd_value[0 +: XLEN]), 64'hDEAD);
        check("cbyp_dep",   64'(rd_dep[0]), 64'(0));
        tick(); idle();
        check("cnt_zero", 64'(busy_cnt), 64'(0));
        settle();
        check("x5_value", 64'(rd_value[XLEN +: XLEN]), 64'hDEAD);

        // stale commit must not clear a newer rename
        issue_valid = 1'b1; issue_rd = 7; issue_rob_id = 1; tick();
        issue_rob_id = 2; tick(); idle();
        commit_valid = 1'b1; commit_rd = 7; commit_rob_id = 1; commit_value = 9;
        tick(); idle();
        check("stale_cnt", 64'(busy_cnt), 64'(1));
        set_addr(7, 7);
        settle();
        check("stale_dep", 64'(rd_dep[0]), 64'(1));
        check("stale_tag", 64'(rd_tag[0 +: ROB_W]), 64'(2));

        // flush with a simultaneous issue
        issue_valid = 1'b1;
        issue_rd = 4; tick(); issue_rd = 6; tick(); issue_rd = 8; tick();
        issue_rd = 9; flush = 1'b1; tick(); idle();
        check("flush_cnt", 64'(busy_cnt), 64'(0));
        set_addr(7, 9);
        settle();
        check("flush_dep",  64'(rd_dep), 64'(0));
        check("x7_value",   64'(rd_value[0 +: XLEN]), 64'(9));

        // x0 issue and frozen state
        issue_valid = 1'b1; issue_rd = 0; issue_rob_id = 5; tick(); idle();
        check("x0_cnt", 64'(busy_cnt), 64'(0));
        rdy = 1'b0; commit_valid = 1'b1; commit_rd = 3; commit_value = 7; tick(); idle();
        set_addr(3, 0);
        settle();
        check("frozen_x3", 64'(rd_value[0 +: XLEN]), 64'(0));
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            int r;
            idle();
            rst          = ($urandom_range(0, 99) == 0);
            rdy          = ($urandom_range(0, 7) != 0);
            flush        = ($urandom_range(0, 15) == 0);
            issue_valid  = $urandom_range(0, 1) == 1;
            issue_rd     = AW'($urandom_range(0, 7));
            issue_rob_id = ROB_W'($urandom);
            commit_valid = $urandom_range(0, 1) == 1;
            r            = $urandom_range(0, 7);
            commit_rd    = AW'(r);
            commit_rob_id = (m_busy[r] && $urandom_range(0, 3) != 0) ? m_tag[r] : ROB_W'($urandom);
            commit_value = $urandom;
            get_ready    = NREAD'($urandom);
            get_value    = {$urandom, $urandom};
            set_addr($urandom_range(0, 7), $urandom_range(0, 7));
            settle();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
